// File: rtl/seq_restoring_divider.sv
// Unsigned N/N restoring divider, one quotient bit per clock.
// Start/done handshake; divide-by-zero reported alongside done.
module seq_restoring_divider #(
  parameter int N     = 16,
  parameter int CNT_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t         state;
  logic [CNT_W-1:0] cnt;
  logic [N:0]     rem_r;
  logic [N-1:0]   q_r;
  logic [N-1:0]   dvs_r;
  logic           dz_r;

  logic [N:0]     r_sh;
  logic [N:0]     diff;
  logic           fits;
  logic [N:0]     rem_nx;
  logic [N-1:0]   q_nx;

  // One restoring step: shift in next dividend bit, trial subtract
  always_comb begin
    r_sh   = {rem_r[N-1:0], q_r[N-1]};
    diff   = r_sh - {1'b0, dvs_r};
    fits   = ~diff[N];
    rem_nx = fits ? diff : r_sh;
    q_nx   = {q_r[N-2:0], fits};
  end

  // Control FSM with registered outputs; a zero divisor takes a
  // single pass through CALC so its done lands one edge after start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rem_r       <= '0;
      q_r         <= '0;
      dvs_r       <= '0;
      dz_r        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            q_r   <= dividend;
            dvs_r <= divisor;
            rem_r <= '0;
            busy  <= 1'b1;
            state <= CALC;
            if (divisor == '0) begin
              dz_r <= 1'b1;
              cnt  <= CNT_W'(1);
            end else begin
              dz_r        <= 1'b0;
              cnt         <= CNT_W'(N);
              div_by_zero <= 1'b0;
            end
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          if (dz_r) begin
            quotient    <= '1;
            remainder   <= q_r;
            div_by_zero <= 1'b1;
            done        <= 1'b1;
            busy        <= 1'b0;
            cnt         <= '0;
            state       <= DONE;
          end else begin
            rem_r <= rem_nx;
            q_r   <= q_nx;
            if (cnt == CNT_W'(1)) begin
              quotient  <= q_nx;
              remainder <= rem_nx[N-1:0];
              done      <= 1'b1;
              busy      <= 1'b0;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and randomized checks of seq_restoring_divider
// against a plain-arithmetic reference.
module tb_seq_restoring_divider;

  localparam int N = 16;
  localparam int M = 2000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  seq_restoring_divider #(.N(N), .CNT_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // edges until done is seen, bounded
  task automatic wait_done(output int k);
    k = 0;
    do begin
      step();
      k++;
    end while (!done && k < 100);
    if (!done) chk("timeout", {31'b0, done}, 32'd1);
  endtask

  function automatic void ref_div(input logic [N-1:0] a,
                                  input logic [N-1:0] b,
                                  output logic [N-1:0] q,
                                  output logic [N-1:0] r);
    if (b == 0) begin
      q = '1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic check_res(input string tag, input logic [N-1:0] a,
                           input logic [N-1:0] b);
    logic [N-1:0] q, r;
    ref_div(a, b, q, r);
    chk({tag, "_q"}, 32'(quotient), 32'(q));
    chk({tag, "_r"}, 32'(remainder), 32'(r));
    chk({tag, "_dz"}, {31'b0, div_by_zero}, {31'b0, b == 0});
  endtask

  initial begin
    int k;
    logic [N-1:0] a, b;
    rst_n    = 1'b0;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) step();
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_dz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1: 100/7, 16-edge latency
    launch(16'd100, 16'd7);
    chk("t1_busy", {31'b0, busy}, 32'd1);
    wait_done(k);
    chk("t1_lat", k, 32'd16);
    chk("t1_busy_end", {31'b0, busy}, 32'd0);
    chk("t1_q_abs", 32'(quotient), 32'd14);
    chk("t1_r_abs", 32'(remainder), 32'd2);
    check_res("t1", 16'd100, 16'd7);
    step();
    chk("t1_pulse", {31'b0, done}, 32'd0);

    // 2: divisor 1, then dividend < divisor
    launch(16'hFFFF, 16'd1);
    wait_done(k);
    check_res("t2a", 16'hFFFF, 16'd1);
    launch(16'd3, 16'd10);
    wait_done(k);
    check_res("t2b", 16'd3, 16'd10);
    launch(16'd0, 16'd9);
    wait_done(k);
    chk("t2c_lat", k, 32'd16);
    check_res("t2c", 16'd0, 16'd9);

    // 3: divide by zero
    launch(16'd5, 16'd0);
    wait_done(k);
    chk("t3_lat", k, 32'd1);
    check_res("t3", 16'd5, 16'd0);
    chk("t3_q_abs", 32'(quotient), 32'hFFFF);
    launch(16'd20, 16'd6);
    wait_done(k);
    check_res("t3_clear", 16'd20, 16'd6);

    // 4: start while busy is ignored
    launch(16'd1000, 16'd33);
    repeat (4) step();
    dividend = 16'd9;
    divisor  = 16'd3;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_done(k);
    chk("t4_lat", k, 32'd11);
    chk("t4_q_abs", 32'(quotient), 32'd30);
    check_res("t4", 16'd1000, 16'd33);

    // 5: reset mid-operation aborts
    launch(16'd50000, 16'd123);
    repeat (7) step();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_q", 32'(quotient), 32'd0);
    chk("t5_r", 32'(remainder), 32'd0);
    k = 0;
    repeat (20) begin
      step();
      if (done) k++;
    end
    rst_n = 1'b1;
    repeat (20) begin
      step();
      if (done) k++;
    end
    chk("t5_nodone", k, 32'd0);
    launch(16'd50000, 16'd123);
    wait_done(k);
    chk("t5_q_abs", 32'(quotient), 32'd406);
    chk("t5_r_abs", 32'(remainder), 32'd62);

    // 6: back-to-back random, start held through DONE
    a = $urandom;
    b = 16'($urandom) >> $urandom_range(0, 15);
    if (b == 0) b = 1;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    for (int i = 0; i < M; i++) begin
      wait_done(k);
      chk("t6_period", k, (i == 0) ? 32'd16 : 32'd17);
      check_res("t6", a, b);
      chk("t6_inv", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
      chk("t6_rlt", {31'b0, remainder < b}, 32'd1);
      if (i < M - 1) begin
        a = $urandom;
        b = 16'($urandom) >> $urandom_range(0, 15);
        if (b == 0) b = 1;
        dividend = a;
        divisor  = b;
      end else begin
        start = 1'b0;
      end
    end
    step();
    chk("t6_idle", {31'b0, busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
